// File: rtl/fft_unloader_pkg.sv
// fft_unloader_pkg: shared FFT helpers; bitrev is reused by the butterfly address generator.
package fft_unloader_pkg;
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[5'(i)] = v[5'(w - 1 - i)];
      return r;
   endfunction
endpackage

// File: rtl/fft_unload_fifo.sv
// fft_unload_fifo: small synchronous FIFO with a registered-pointer head; reset clears pointers only.
module fft_unload_fifo
   import fft_unloader_pkg::*;
#(
   parameter int WIDTH = 45,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wptr, rptr;
   assign empty = count == '0;
   assign full = count == CW'(DEPTH);
   assign rdata = mem[rptr];
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
         if (pop) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
   end
endmodule

// File: rtl/fft_unloader.sv
// fft_unloader: streams the FFT RAM out in bit-reversed read order so bins leave in natural order.
// Define FFT_UNLOAD_HALF_EN to emit only bins 0..N/2 (real-input spectrum).
module fft_unloader
   import fft_unloader_pkg::*;
#(
   parameter int FFT_SIZE = 4096,
   parameter int DATA_W = 32,
   parameter int RAM_LATENCY = 2,
   parameter int FIFO_DEPTH = 4,
   localparam int LEVELS = $clog2(FFT_SIZE)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              unload_go,
   output logic              unload_busy,
   output logic              unload_done,
   output logic              ram_re,
   output logic [LEVELS-1:0] ram_raddr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [LEVELS-1:0] out_index,
   output logic              out_last
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = LEVELS + 1;
   localparam int LW = RAM_LATENCY * EW;
   localparam int FW = DATA_W + EW;
`ifdef FFT_UNLOAD_HALF_EN
   localparam logic [LEVELS-1:0] K_LAST = LEVELS'(FFT_SIZE / 2);
`else
   localparam logic [LEVELS-1:0] K_LAST = LEVELS'(FFT_SIZE - 1);
`endif
   typedef enum logic [1:0] {IDLE, READING, DRAINING} state_t;
   state_t state, state_nx;
   logic [LEVELS-1:0] k;
   logic [RAM_LATENCY-1:0] dl_v;
   logic [LW-1:0] dl_kl;
   logic [CW-1:0] fifo_count;
   logic fifo_empty, fifo_full, issue, pop;
   logic [FW-1:0] fifo_rdata;
   // Credit check counts reads still inside the RAM pipe, so the FIFO cannot overflow under any backpressure.
   assign issue = state == READING && !fifo_full && (int'(fifo_count) + $countones(dl_v) < FIFO_DEPTH);
   assign ram_re = issue;
   assign ram_raddr = LEVELS'(bitrev(32'(k), LEVELS));
   assign pop = out_valid & out_ready;
   assign unload_done = state == DRAINING && dl_v == '0 && fifo_empty;
   assign unload_busy = state != IDLE && !unload_done;
   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE && unload_go) ? READING :
                 (issue && k == K_LAST) ? DRAINING :
                 unload_done ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         k <= '0;
         dl_v <= '0;
      end else begin
         state <= state_nx;
         k <= (state == IDLE && unload_go) ? '0 : issue ? k + 1'b1 : k;
         dl_v <= RAM_LATENCY'({dl_v, issue});
      end
   end
   always_ff @(posedge clk) begin
      dl_kl <= LW'({dl_kl, k, k == K_LAST});
   end
   fft_unload_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (dl_v[RAM_LATENCY-1]),
      .pop   (pop),
      .wdata ({ram_rdata, dl_kl[LW-1 -: EW]}),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );
   assign out_valid = !fifo_empty;
   assign out_data = fifo_rdata[FW-1 -: DATA_W];
   assign out_index = out_valid ? fifo_rdata[LEVELS:1] : '0;
   assign out_last = out_valid & fifo_rdata[0];
endmodule
